// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: three writeback sources, the issue-stage scoreboard
// query, and the register-bank write port.
interface wb_port_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            req0_valid;
  logic [4:0]      req0_rd;
  logic [XLEN-1:0] req0_val;
  logic            req0_ready;

  logic            req1_valid;
  logic [4:0]      req1_rd;
  logic [XLEN-1:0] req1_val;
  logic            req1_ready;

  logic            req2_valid;
  logic [4:0]      req2_rd;
  logic [XLEN-1:0] req2_val;
  logic            req2_ready;

  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic [4:0]      chk_rd;
  logic            stall;

  logic            reg_we;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_val;

  // Writeback sources, issue stage and bank side.
  modport master (
    output req0_valid, req0_rd, req0_val,
    output req1_valid, req1_rd, req1_val,
    output req2_valid, req2_rd, req2_val,
    output iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
    input  req0_ready, req1_ready, req2_ready,
    input  stall, reg_we, rd, rd_val
  );

  // The arbiter itself.
  modport slave (
    input  req0_valid, req0_rd, req0_val,
    input  req1_valid, req1_rd, req1_val,
    input  req2_valid, req2_rd, req2_val,
    input  iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
    output req0_ready, req1_ready, req2_ready,
    output stall, reg_we, rd, rd_val
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port among three
// writeback sources, plus a per-register pending-write scoreboard for issue stalls.
module wb_port_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  logic [1:0]      ptr_q, ptr_d;
  logic            reg_we_q, reg_we_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rd_val_q, rd_val_d;
  logic [31:0]     pend_q, pend_d;

  logic [2:0]      valid;
  logic [1:0]      cand0, cand1, cand2;
  logic [2:0]      gnt;
  logic            gnt_any;
  logic [1:0]      gnt_idx;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_val;

  function automatic logic [1:0] next_idx(input logic [1:0] k);
    return (k >= 2'd2) ? 2'd0 : k + 2'd1;
  endfunction

  assign valid = {bus.req2_valid, bus.req1_valid, bus.req0_valid};

  // Search valids starting at ptr; readies are forced low during reset.
  always_comb begin
    cand0   = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
    cand1   = next_idx(cand0);
    cand2   = next_idx(cand1);
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    if (!rst) begin
      if (valid[cand0]) begin
        gnt_any = 1'b1;
        gnt_idx = cand0;
      end else if (valid[cand1]) begin
        gnt_any = 1'b1;
        gnt_idx = cand1;
      end else if (valid[cand2]) begin
        gnt_any = 1'b1;
        gnt_idx = cand2;
      end
    end
    gnt = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
  end

  // Select the granted source's destination and data.
  always_comb begin
    sel_rd  = bus.req0_rd;
    sel_val = bus.req0_val;
    case (gnt_idx)
      2'd1: begin
        sel_rd  = bus.req1_rd;
        sel_val = bus.req1_val;
      end
      2'd2: begin
        sel_rd  = bus.req2_rd;
        sel_val = bus.req2_val;
      end
      default: begin
        sel_rd  = bus.req0_rd;
        sel_val = bus.req0_val;
      end
    endcase
  end

  // Next pointer, output register and scoreboard; x0 grants are consumed silently.
  always_comb begin
    ptr_d    = ptr_q;
    reg_we_d = 1'b0;
    rd_d     = rd_q;
    rd_val_d = rd_val_q;
    pend_d   = pend_q;
    if (gnt_any) begin
      ptr_d = next_idx(gnt_idx);
      if (sel_rd != 5'd0) begin
        reg_we_d = 1'b1;
        rd_d     = sel_rd;
        rd_val_d = sel_val;
      end
    end
    // Clear first so a same-cycle issue to the same register wins.
    if (reg_we_q) pend_d[rd_q] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != 5'd0)) pend_d[bus.iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= 2'd0;
      reg_we_q <= 1'b0;
      rd_q     <= 5'd0;
      rd_val_q <= '0;
      pend_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      reg_we_q <= reg_we_d;
      rd_q     <= rd_d;
      rd_val_q <= rd_val_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.req2_ready = gnt[2];
  assign bus.reg_we     = reg_we_q;
  assign bus.rd         = rd_q;
  assign bus.rd_val     = rd_val_q;
  assign bus.stall      = pend_q[bus.chk_rs1] | pend_q[bus.chk_rs2] | pend_q[bus.chk_rd];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench: expected grants and bank writes go into queues, a negedge
// monitor pops and compares them; stall/reset behaviour is checked inline.
module tb_wb_port_arbiter;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_gnt[$];
  wr_t  exp_wr[$];

  wb_port_arbiter_if #(.XLEN(32)) bus ();

  wb_port_arbiter #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] rd, input logic [31:0] val);
    wr_t w;
    w.rd  = rd;
    w.val = val;
    exp_wr.push_back(w);
  endtask

  // Monitor: every grant and every bank write must match the next queued expectation.
  always @(negedge clk) begin
    logic [2:0] r;
    int         idx;
    wr_t        w;
    if (!rst) begin
      r = {bus.req2_ready, bus.req1_ready, bus.req0_ready};
      if (r != 3'b000) begin
        case (r)
          3'b001:  idx = 0;
          3'b010:  idx = 1;
          3'b100:  idx = 2;
          default: idx = 9;
        endcase
        if (exp_gnt.size() == 0) check("unexpected_grant", 64'(r), 64'(0));
        else check("grant_index", 64'(idx), 64'(exp_gnt.pop_front()));
      end
      if (bus.reg_we) begin
        if (exp_wr.size() == 0) check("unexpected_write", 64'(bus.rd), 64'hdead);
        else begin
          w = exp_wr.pop_front();
          check("write_rd", 64'(bus.rd), 64'(w.rd));
          check("write_val", 64'(bus.rd_val), 64'(w.val));
        end
      end
    end
  end

  initial begin
    bus.req0_valid = 1'b1; bus.req0_rd = 5'd5; bus.req0_val = 32'hA;
    bus.req1_valid = 1'b1; bus.req1_rd = 5'd6; bus.req1_val = 32'hB;
    bus.req2_valid = 1'b1; bus.req2_rd = 5'd7; bus.req2_val = 32'hC;
    bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
    bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd0; bus.chk_rd = 5'd0;

    // Reset with all sources requesting
    for (int i = 0; i < 2; i++) begin
      mid();
      check("rst_ready", 64'({bus.req2_ready, bus.req1_ready, bus.req0_ready}), 64'(0));
      cyc();
    end
    rst = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.req2_valid = 1'b0;
    bus.chk_rs1 = 5'd5;
    mid();
    check("post_rst_reg_we", 64'(bus.reg_we), 64'(0));
    check("post_rst_rd", 64'(bus.rd), 64'(0));
    check("post_rst_rd_val", 64'(bus.rd_val), 64'(0));
    check("post_rst_stall", 64'(bus.stall), 64'(0));
    cyc();

    // Round-robin with all three valid: 0,1,2,0 -> ptr ends at 1
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.req2_valid = 1'b1;
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2); exp_gnt.push_back(0);
    push_wr(5'd5, 32'hA); push_wr(5'd6, 32'hB); push_wr(5'd7, 32'hC); push_wr(5'd5, 32'hA);
    repeat (4) cyc();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.req2_valid = 1'b0;
    repeat (2) cyc();

    // Single requester on port 1 -> ptr becomes 2
    bus.req1_valid = 1'b1; bus.req1_rd = 5'd3; bus.req1_val = 32'h1234;
    exp_gnt.push_back(1); push_wr(5'd3, 32'h1234);
    mid();
    check("single_ready1", 64'(bus.req1_ready), 64'(1));
    check("single_no_we_yet", 64'(bus.reg_we), 64'(0));
    cyc();
    bus.req1_valid = 1'b0;
    mid();
    check("single_reg_we", 64'(bus.reg_we), 64'(1));
    check("single_rd", 64'(bus.rd), 64'(3));
    check("single_rd_val", 64'(bus.rd_val), 64'(32'h1234));
    cyc();

    // ptr=2: all valid must grant source 2 first
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.req2_valid = 1'b1;
    bus.req1_rd = 5'd6; bus.req1_val = 32'hB;
    exp_gnt.push_back(2); push_wr(5'd7, 32'hC);
    cyc();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.req2_valid = 1'b0;
    cyc();

    // x0 discard on port 2 with an x0 issue in the same cycle
    bus.req2_valid = 1'b1; bus.req2_rd = 5'd0; bus.req2_val = 32'hFFFF_FFFF;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.chk_rs1 = 5'd0;
    exp_gnt.push_back(2);
    mid();
    check("x0_ready2", 64'(bus.req2_ready), 64'(1));
    cyc();
    bus.req2_valid = 1'b0; bus.iss_valid = 1'b0;
    mid();
    check("x0_reg_we", 64'(bus.reg_we), 64'(0));
    check("x0_rd_hold", 64'(bus.rd), 64'(7));
    check("x0_rd_val_hold", 64'(bus.rd_val), 64'(32'hC));
    check("x0_stall", 64'(bus.stall), 64'(0));
    cyc();

    // Scoreboard lifecycle on x9 (ptr=0)
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; bus.chk_rs1 = 5'd9;
    mid();
    check("sb_c0_stall", 64'(bus.stall), 64'(0));
    cyc();
    bus.iss_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      mid();
      check("sb_pending_stall", 64'(bus.stall), 64'(1));
      cyc();
    end
    bus.req0_valid = 1'b1; bus.req0_rd = 5'd9; bus.req0_val = 32'h99;
    exp_gnt.push_back(0); push_wr(5'd9, 32'h99);
    mid();
    check("sb_c4_stall", 64'(bus.stall), 64'(1));
    cyc();
    bus.req0_valid = 1'b0;
    mid();
    check("sb_c5_reg_we", 64'(bus.reg_we), 64'(1));
    check("sb_c5_stall", 64'(bus.stall), 64'(1));
    cyc();
    mid();
    check("sb_c6_stall", 64'(bus.stall), 64'(0));
    cyc();

    // Simultaneous set/clear on x12 (ptr=1)
    bus.chk_rs1 = 5'd0;
    bus.req1_valid = 1'b1; bus.req1_rd = 5'd12; bus.req1_val = 32'h12;
    exp_gnt.push_back(1); push_wr(5'd12, 32'h12);
    cyc();
    bus.req1_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd12; bus.chk_rs2 = 5'd12;
    mid();
    check("sc_reg_we", 64'(bus.reg_we), 64'(1));
    check("sc_rd", 64'(bus.rd), 64'(12));
    check("sc_stall_before", 64'(bus.stall), 64'(0));
    cyc();
    bus.iss_valid = 1'b0;
    mid();
    check("sc_set_wins_rs2", 64'(bus.stall), 64'(1));
    cyc();
    bus.chk_rs2 = 5'd0; bus.chk_rd = 5'd12;
    mid();
    check("sc_stall_rd", 64'(bus.stall), 64'(1));
    cyc();
    bus.chk_rd = 5'd0;
    mid();
    check("sc_x0_no_stall", 64'(bus.stall), 64'(0));
    cyc();

    // Mid-operation reset: pending bits lost, ready gated (ptr was 2)
    bus.chk_rs2 = 5'd12;
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_rd = 5'd4; bus.req0_val = 32'h44;
    mid();
    check("midrst_ready0", 64'(bus.req0_ready), 64'(0));
    cyc();
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    mid();
    check("midrst_stall", 64'(bus.stall), 64'(0));
    check("midrst_reg_we", 64'(bus.reg_we), 64'(0));
    cyc();

    // ptr back at 0: with 1 and 2 valid, source 1 wins
    bus.req1_valid = 1'b1; bus.req1_rd = 5'd20; bus.req1_val = 32'h20;
    bus.req2_valid = 1'b1; bus.req2_rd = 5'd21; bus.req2_val = 32'h21;
    exp_gnt.push_back(1); push_wr(5'd20, 32'h20);
    cyc();
    bus.req1_valid = 1'b0; bus.req2_valid = 1'b0;
    repeat (3) cyc();

    check("grants_left", 64'(exp_gnt.size()), 64'(0));
    check("writes_left", 64'(exp_wr.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
